ifetch_unit: RTL and testbench
==============================

// Module: ifetch_unit
// PURPOSE
//  Consumer end of the PC: takes pc_out as the next fetch address and issues it to instruction memory over req/gnt.
//  Tracks in-flight requests and buffers returned words with their PC. Presents instructions to decode over valid/ready.
//  Tells the PC when to step (pc_adv). Sits between pc and decode in the V-CORE front end.
// PARAMETERS
//  XLEN     32  address/instruction width
//  DEPTH    4   instruction buffer entries (power of 2, >=2)
//  MAX_OUT  2   max outstanding imem requests (1..DEPTH)
// PORTS
//  clk          in   1     clock, rising edge
//  reset_n      in   1     asynchronous, active-low reset
//  pc_in        in   XLEN  current PC (pc_out of pc)
//  pc_adv       out  1     PC loads pc_next this edge (fetch accepted)
//  flush        in   1     redirect: discard buffered and in-flight fetches
//  imem_req     out  1     fetch request valid
//  imem_addr    out  XLEN  fetch address (= pc_in)
//  imem_gnt     in   1     memory accepts request this cycle
//  imem_rvalid  in   1     read data valid (in order, >=1 cycle after gnt)
//  imem_rdata   in   XLEN  instruction word
//  inst_valid   out  1     buffered instruction available
//  inst_ready   in   1     decode consumes instruction
//  inst_data    out  XLEN  instruction word at buffer head
//  inst_pc      out  XLEN  PC of inst_data
// BEHAVIOUR
//  Async reset (reset_n=0): buffers empty, outstanding=0, drop_cnt=0.
//  - Outputs during reset: imem_req=0, pc_adv=0, inst_valid=0, inst_data=0, inst_pc=0.
//  Counters: out_cnt = requests granted, response not yet seen; buf_cnt = entries held.
//  imem_req = !flush & (out_cnt < MAX_OUT) & (out_cnt + buf_cnt < DEPTH); imem_addr = pc_in (combinational).
//  - Credit check uses registered counts only; no same-cycle pop bypass.
//  Accept = imem_req & imem_gnt.
//  - pc_adv = accept; same cycle, pc_in is pushed into the tag FIFO; out_cnt += 1.
//  Response (imem_rvalid):
//  - if drop_cnt>0: word discarded, drop_cnt -= 1, out_cnt -= 1.
//  - else: {tag head, imem_rdata} pushed to instruction buffer, tag popped, out_cnt -= 1.
//  - Credit rule guarantees the buffer never overflows; rvalid with out_cnt==0 is illegal (ignored, no state change).
//  Output: inst_valid = buf_cnt != 0; inst_data/inst_pc = head entry, registered; 0 when empty.
//  - Pop on inst_valid & inst_ready.
//  - Push and pop in the same cycle: buf_cnt unchanged.
//  - Latency: rvalid at edge N -> inst_valid high after edge N (visible cycle N+1).
//  flush (highest priority):
//  - Buffer and tag FIFO cleared; imem_req=0; pc_adv=0 (PC is loaded by redirect logic).
//  - drop_cnt <= out_cnt - (imem_rvalid ? 1 : 0); that rvalid word is discarded.
//  - Pops that cycle are ignored; inst_valid=0 from next cycle.
//  - Flush while drop_cnt>0: drop_cnt recomputed the same way (all in-flight are stale).
//  - Requests resume the cycle after flush; new responses are accepted only after drop_cnt reaches 0.
//  Pointers wrap modulo DEPTH; counters are width clog2(DEPTH)+1, never exceed DEPTH.
//  gnt without req is ignored; rvalid and accept in the same cycle: out_cnt unchanged.
// STRUCTURE
//  vcore_pkg:
//  - XLEN, INSTR_NOP = 32'h0000_0013, typedef fetch_entry_t {pc, instr}.
//  Sub-module sync_fifo (WIDTH, DEPTH; push/pop/full/empty/count, async active-low reset):
//  - instance for the tag FIFO (XLEN, MAX_OUT);
//  - instance for the instruction buffer (2*XLEN, DEPTH).
//  Top level holds out_cnt, drop_cnt, credit logic, flush control.
// TESTING
//  - Reset: reset_n=0 mid-stream with 2 outstanding -> all outputs 0 immediately; after release, first req addr = pc_in.
//  - Streaming: gnt=1, rvalid 1 cycle later, inst_ready=1, pc 0,4,8.. ->
//    - inst_pc 0,4,8 in order, inst_data matches memory;
//    - one pc_adv per accept.
//  - Backpressure: inst_ready=0, gnt=1, DEPTH=4 ->
//    - at most 4 accepts total, then imem_req=0 and pc_adv=0;
//    - req resumes the cycle after the first pop.
//  - Outstanding cap: rvalid withheld 10 cycles -> exactly MAX_OUT=2 accepts; out_cnt=2 until responses.
//  - Flush with 2 in flight, one rvalid same cycle ->
//    - drop_cnt=1; next response discarded;
//    - first post-flush response (pc 0x100) is the first inst_valid, inst_pc=0x100.
//  - Simultaneous push/pop at buf_cnt=DEPTH-1 with wrap across index 3->0 -> order preserved; no loss or duplicate.

Source files
------------

// File: rtl/vcore_pkg.sv
// Shared V-CORE front-end constants and the fetch buffer entry layout.
package vcore_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Small register-file FIFO with synchronous clear; head word is visible
// combinationally from storage and reads as zero while empty.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  // Explicit wrap keeps non-power-of-two depths (e.g. MAX_OUT=3) correct.
  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = empty ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch: issues pc_in to imem under a credit limit, pairs returned
// words with their PC and buffers them for decode; flush drops stale traffic.
module ifetch_unit
  import vcore_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [XLEN-1:0] pc_in,
  output logic            pc_adv,
  input  logic            flush,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(MAX_OUT) + 1;

  logic [CW-1:0]   out_cnt_q, out_cnt_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
  logic [CW-1:0]   buf_cnt;
  logic [CW:0]     credit_sum;
  logic            accept, rsp, drop, keep;
  logic [XLEN-1:0] tag_pc;
  fetch_entry_t    buf_in, buf_out;
  logic            buf_empty, buf_full;
  logic            tag_full, tag_empty;
  logic [TW-1:0]   tag_count;
  logic            unused_ok;

  // Credits come from registered counts only, so a pop never frees a slot
  // for a request in the same cycle.
  assign credit_sum = {1'b0, out_cnt_q} + {1'b0, buf_cnt};
  assign imem_req   = reset_n & ~flush & (out_cnt_q < CW'(MAX_OUT))
                      & (credit_sum < (CW + 1)'(DEPTH));
  assign imem_addr  = pc_in;
  assign accept     = imem_req & imem_gnt;
  assign pc_adv     = accept;

  // A response with nothing in flight is ignored outright.
  assign rsp  = imem_rvalid & (out_cnt_q != '0);
  assign drop = rsp & (flush | (drop_cnt_q != '0));
  assign keep = rsp & ~drop;

  always_comb begin
    out_cnt_d  = out_cnt_q + CW'(accept) - CW'(rsp);
    drop_cnt_d = drop_cnt_q;
    if (flush) begin
      drop_cnt_d = out_cnt_q - CW'(rsp);
    end else if (drop) begin
      drop_cnt_d = drop_cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  sync_fifo #(.WIDTH(XLEN), .DEPTH(MAX_OUT)) u_tag_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (flush),
    .push    (accept),
    .din     (pc_in),
    .pop     (keep),
    .dout    (tag_pc),
    .full    (tag_full),
    .empty   (tag_empty),
    .count   (tag_count)
  );

  assign buf_in = {tag_pc, imem_rdata};

  sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_inst_buf (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (flush),
    .push    (keep),
    .din     (buf_in),
    .pop     (inst_valid & inst_ready),
    .dout    (buf_out),
    .full    (buf_full),
    .empty   (buf_empty),
    .count   (buf_cnt)
  );

  assign inst_valid = ~buf_empty;
  assign inst_data  = buf_out.instr;
  assign inst_pc    = buf_out.pc;

  assign unused_ok = &{1'b0, tag_full, tag_empty, tag_count, buf_full};

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit with a one-cycle-latency memory responder.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] pc_in;
  logic        pc_adv;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_acc   = 0;
  int          n_adv   = 0;
  bit          rsp_en  = 1'b0;
  logic [31:0] pend[$];
  logic [31:0] gpc[$];
  logic [31:0] gdat[$];

  always #5 clk = ~clk;

  ifetch_unit #(.DEPTH(4), .MAX_OUT(2)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .pc_in       (pc_in),
    .pc_adv      (pc_adv),
    .flush       (flush),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst_data   (inst_data),
    .inst_pc     (inst_pc)
  );

  function automatic logic [31:0] memw(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, a[15:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("[TB] ok %s: 0x%08h", tag, got);
    end
  endtask

  // One clock: sample pre-edge, then update PC, memory and sink models.
  task automatic cyc();
    logic acc, rsp, pop, adv;
    logic [31:0] a, ppc, pdat;
    #1;
    acc  = imem_req & imem_gnt;
    adv  = pc_adv;
    a    = imem_addr;
    rsp  = imem_rvalid;
    pop  = inst_valid & inst_ready & ~flush;
    ppc  = inst_pc;
    pdat = inst_data;
    @(posedge clk);
    @(negedge clk);
    if (adv) n_adv++;
    if (acc) begin
      pend.push_back(a);
      n_acc++;
      pc_in = pc_in + 32'd4;
    end
    if (rsp && pend.size() > 0) void'(pend.pop_front());
    if (pop) begin
      gpc.push_back(ppc);
      gdat.push_back(pdat);
    end
    if (rsp_en && pend.size() > 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = memw(pend[0]);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic do_reset(input logic [31:0] pc0);
    reset_n = 1'b0; flush = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
    imem_rdata = '0; inst_ready = 1'b0; rsp_en = 1'b0; pc_in = pc0;
    pend.delete(); gpc.delete(); gdat.delete();
    n_acc = 0; n_adv = 0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic check_seq(input string tag, input logic [31:0] base, input int n);
    check({tag, "_count"}, 32'(gpc.size()), 32'(n));
    for (int i = 0; i < n && i < gpc.size(); i++) begin
      check($sformatf("%s_pc%0d", tag, i), gpc[i], base + 32'(4 * i));
      check($sformatf("%s_data%0d", tag, i), gdat[i], memw(base + 32'(4 * i)));
    end
  endtask

  initial begin
    // Power-on reset
    reset_n = 1'b1; flush = 1'b0; imem_gnt = 1'b1; imem_rvalid = 1'b0;
    imem_rdata = '0; inst_ready = 1'b0; pc_in = 32'h0;
    #1 reset_n = 1'b0;
    #1;
    check("rst_req", 32'(imem_req), 32'h0);
    check("rst_adv", 32'(pc_adv), 32'h0);
    check("rst_valid", 32'(inst_valid), 32'h0);
    check("rst_data", inst_data, 32'h0);
    check("rst_pc", inst_pc, 32'h0);
    imem_gnt = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("rel_req", 32'(imem_req), 32'h1);
    check("rel_addr", imem_addr, 32'h0);

    // Streaming, one accept per cycle
    imem_gnt = 1'b1; rsp_en = 1'b1; inst_ready = 1'b1;
    run(10);
    imem_gnt = 1'b0;
    run(6);
    check("stream_acc", 32'(n_acc), 32'd10);
    check("stream_adv", 32'(n_adv), 32'd10);
    check_seq("stream", 32'h0, 10);
    check("stream_empty", 32'(inst_valid), 32'h0);

    // Backpressure: buffer of 4 fills, then request waits for a pop
    do_reset(32'h0);
    imem_gnt = 1'b1; rsp_en = 1'b1;
    run(12);
    check("bp_acc", 32'(n_acc), 32'd4);
    #1;
    check("bp_req", 32'(imem_req), 32'h0);
    check("bp_adv", 32'(pc_adv), 32'h0);
    check("bp_head", inst_pc, 32'h0);
    inst_ready = 1'b1;
    #1;
    check("bp_nobypass", 32'(imem_req), 32'h0);
    run(1);
    inst_ready = 1'b0;
    #1;
    check("bp_resume", 32'(imem_req), 32'h1);
    run(1);
    imem_gnt = 1'b0; inst_ready = 1'b1;
    run(8);
    check("bp_acc2", 32'(n_acc), 32'd5);
    check_seq("bp", 32'h0, 5);

    // Outstanding cap with responses withheld
    do_reset(32'h0);
    imem_gnt = 1'b1; inst_ready = 1'b1;
    run(10);
    check("cap_acc", 32'(n_acc), 32'd2);
    check("cap_out", 32'(dut.out_cnt_q), 32'd2);
    #1;
    check("cap_req", 32'(imem_req), 32'h0);
    imem_gnt = 1'b0; rsp_en = 1'b1;
    run(1);
    check("cap_out_hold", 32'(dut.out_cnt_q), 32'd2);
    run(5);
    check("cap_out_done", 32'(dut.out_cnt_q), 32'd0);
    check_seq("cap", 32'h0, 2);

    // Flush with two in flight and one response in the flush cycle
    do_reset(32'h0);
    imem_gnt = 1'b1;
    run(4);
    check("fl_acc", 32'(n_acc), 32'd2);
    imem_rvalid = 1'b1; imem_rdata = memw(32'h0); flush = 1'b1;
    #1;
    check("fl_req", 32'(imem_req), 32'h0);
    check("fl_adv", 32'(pc_adv), 32'h0);
    run(1);
    check("fl_drop", 32'(dut.drop_cnt_q), 32'd1);
    check("fl_out", 32'(dut.out_cnt_q), 32'd1);
    check("fl_valid", 32'(inst_valid), 32'h0);
    flush = 1'b0; pc_in = 32'h100;
    #1;
    check("fl_resume", 32'(imem_req), 32'h1);
    check("fl_addr", imem_addr, 32'h100);
    run(1);
    imem_gnt = 1'b0; rsp_en = 1'b1; inst_ready = 1'b1;
    run(6);
    check_seq("fl", 32'h100, 1);
    check("fl_drop_end", 32'(dut.drop_cnt_q), 32'd0);
    check("fl_out_end", 32'(dut.out_cnt_q), 32'd0);

    // Push and pop together at DEPTH-1 while the write index wraps 3->0
    do_reset(32'h0);
    imem_gnt = 1'b1; rsp_en = 1'b1;
    run(8);
    check("wr_fill", 32'(n_acc), 32'd4);
    imem_gnt = 1'b0; inst_ready = 1'b1;
    run(1);
    inst_ready = 1'b0; imem_gnt = 1'b1;
    run(1);
    imem_gnt = 1'b0; inst_ready = 1'b1;
    #1;
    check("wr_head", inst_pc, 32'h4);
    run(1);
    check("wr_cnt", 32'(dut.buf_cnt), 32'd3);
    check("wr_head2", inst_pc, 32'h8);
    imem_gnt = 1'b1;
    run(10);
    imem_gnt = 1'b0;
    run(10);
    check_seq("wr", 32'h0, n_acc);

    // Asynchronous reset mid-stream with two outstanding
    do_reset(32'h0);
    imem_gnt = 1'b1; rsp_en = 1'b1;
    run(2);
    rsp_en = 1'b0;
    run(3);
    check("mr_out", 32'(dut.out_cnt_q), 32'd2);
    check("mr_valid_pre", 32'(inst_valid), 32'h1);
    #1 reset_n = 1'b0;
    #1;
    check("mr_req", 32'(imem_req), 32'h0);
    check("mr_adv", 32'(pc_adv), 32'h0);
    check("mr_valid", 32'(inst_valid), 32'h0);
    check("mr_data", inst_data, 32'h0);
    check("mr_pc", inst_pc, 32'h0);
    check("mr_out0", 32'(dut.out_cnt_q), 32'd0);
    pend.delete(); imem_rvalid = 1'b0; imem_gnt = 1'b0; pc_in = 32'h200;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("mr_req_rel", 32'(imem_req), 32'h1);
    check("mr_addr_rel", imem_addr, 32'h200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
